// File: rtl/rx_header_parser_tx_inserter.sv
// TX header inserter: frames one latched descriptor as a 7-beat 32-bit AXI-Stream header,
// then passes the payload stream through verbatim until its tlast.
module rx_header_parser_tx_inserter #(
  parameter int          C_AXIS_TDATA_WIDTH = 32,
  parameter int          C_AXIS_TKEEP_WIDTH = 4,
  parameter logic [23:0] HDR_PAD_PATTERN    = 24'hABABAB
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          hdr_valid,
  output logic                          hdr_ready,
  input  logic [7:0]                    hdr_opcode,
  input  logic [23:0]                   hdr_psn,
  input  logic [23:0]                   hdr_dest_qp,
  input  logic [31:0]                   hdr_remote_addr,
  input  logic [15:0]                   hdr_frag_offset,
  input  logic [31:0]                   hdr_length,
  input  logic [15:0]                   hdr_partition_key,
  input  logic [7:0]                    hdr_service_level,
  input  logic                          hdr_no_payload,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic [15:0]                   tx_pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
  } state_e;

  localparam logic [2:0] LAST_BEAT = 3'd6;

  state_e      state_q, state_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        load_desc;

  logic [7:0]  opcode_q;
  logic [23:0] psn_q;
  logic [23:0] dest_qp_q;
  logic [31:0] remote_addr_q;
  logic [15:0] frag_offset_q;
  logic [31:0] length_q;
  logic [15:0] partition_key_q;
  logic [7:0]  service_level_q;
  logic        no_payload_q;
  logic [31:0] hdr_beat;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the reset here is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      opcode_q        <= '0;
      psn_q           <= '0;
      dest_qp_q       <= '0;
      remote_addr_q   <= '0;
      frag_offset_q   <= '0;
      length_q        <= '0;
      partition_key_q <= '0;
      service_level_q <= '0;
      no_payload_q    <= 1'b0;
    end else if (load_desc) begin
      opcode_q        <= hdr_opcode;
      psn_q           <= hdr_psn;
      dest_qp_q       <= hdr_dest_qp;
      remote_addr_q   <= hdr_remote_addr;
      frag_offset_q   <= hdr_frag_offset;
      length_q        <= hdr_length;
      partition_key_q <= hdr_partition_key;
      service_level_q <= hdr_service_level;
      no_payload_q    <= hdr_no_payload;
    end
  end

  // Header words come only from registers, so they hold steady across output stalls.
  always_comb begin
    hdr_beat = '0;
    unique case (beat_cnt_q)
      3'd0:    hdr_beat = {psn_q, opcode_q};
      3'd1:    hdr_beat = {8'h00, dest_qp_q};
      3'd2:    hdr_beat = remote_addr_q;
      3'd3:    hdr_beat = {16'h0000, frag_offset_q};
      3'd4:    hdr_beat = length_q;
      3'd5:    hdr_beat = {16'h0000, partition_key_q};
      3'd6:    hdr_beat = {HDR_PAD_PATTERN, service_level_q};
      default: hdr_beat = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    load_desc     = 1'b0;
    hdr_ready     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hdr_ready = !areset;
        if (hdr_valid && !areset) begin
          load_desc  = 1'b1;
          beat_cnt_d = '0;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = '1;
        m_axis_tdata  = hdr_beat;
        m_axis_tlast  = no_payload_q && (beat_cnt_q == LAST_BEAT);
        if (m_axis_tready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (no_payload_q) begin
              state_d   = S_IDLE;
              pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
              state_d = S_PAYLOAD;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      S_PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d   = S_IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign tx_pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_rx_header_parser_tx_inserter.sv
// Randomised bench for rx_header_parser_tx_inserter: a queue-based packet model predicts
// every output beat, the packet count and the header-to-payload latency.
module tb_rx_header_parser_tx_inserter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        hdr_valid, hdr_ready, hdr_no_payload;
  logic [7:0]  hdr_opcode, hdr_service_level;
  logic [23:0] hdr_psn, hdr_dest_qp;
  logic [31:0] hdr_remote_addr, hdr_length;
  logic [15:0] hdr_frag_offset, hdr_partition_key;
  logic [31:0] s_tdata, m_tdata;
  logic [3:0]  s_tkeep, m_tkeep;
  logic        s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
  logic        busy;
  logic [15:0] tx_pkt_count;

  always #5 aclk = ~aclk;

  rx_header_parser_tx_inserter dut (
    .aclk(aclk), .areset(areset),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_opcode(hdr_opcode),
    .hdr_psn(hdr_psn), .hdr_dest_qp(hdr_dest_qp), .hdr_remote_addr(hdr_remote_addr),
    .hdr_frag_offset(hdr_frag_offset), .hdr_length(hdr_length),
    .hdr_partition_key(hdr_partition_key), .hdr_service_level(hdr_service_level),
    .hdr_no_payload(hdr_no_payload),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .busy(busy), .tx_pkt_count(tx_pkt_count)
  );

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [23:0] qp;
    logic [31:0] addr;
    logic [15:0] off;
    logic [31:0] len;
    logic [15:0] pkey;
    logic [7:0]  sl;
    logic        np;
  } desc_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t pay_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    hdr_left = 0;
  int    rdy_mode = 0;
  bit    pay_first = 0;
  bit    lat_chk = 0;
  bit    src_always = 0;
  bit    noise_en = 0;
  bit    post_chk = 0;
  logic [15:0] model_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Downstream ready pattern: held high, toggling, or random.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Payload source: holds a presented beat until it is taken.
  initial begin
    bit hs;
    s_tvalid = 0; s_tdata = 0; s_tkeep = 0; s_tlast = 0;
    forever begin
      @(negedge aclk);
      hs = s_tvalid && s_tready;
      @(posedge aclk); #1;
      if (hs && pay_q.size() > 0) void'(pay_q.pop_front());
      if (!(s_tvalid && !hs)) begin
        if (pay_q.size() > 0 && (src_always || $urandom_range(0, 2) != 0)) begin
          s_tvalid = 1'b1;
          {s_tdata, s_tkeep, s_tlast} = pay_q[0];
        end else begin
          s_tvalid = 1'b0;
        end
      end
    end
  end

  // Mid-packet descriptor noise, only asserted when the packet cannot end this cycle.
  initial begin
    forever begin
      @(posedge aclk); #3;
      if (noise_en) begin
        hdr_opcode = 8'($urandom); hdr_psn = 24'($urandom); hdr_dest_qp = 24'($urandom);
        hdr_remote_addr = $urandom; hdr_frag_offset = 16'($urandom);
        hdr_length = $urandom; hdr_partition_key = 16'($urandom);
        hdr_service_level = 8'($urandom); hdr_no_payload = 1'($urandom);
        hdr_valid = busy && (hdr_left >= 2 || (hdr_left == 0 && pay_q.size() >= 2))
                    && ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    bit          stall_prev = 0;
    logic [31:0] prev_data = 0;
    beat_t       b;
    forever begin
      @(negedge aclk);
      if (post_chk) begin
        check("count_after_pkt", tx_pkt_count, model_count);
        check("idle_after_pkt", busy, 0);
        post_chk = 0;
      end
      if (stall_prev) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, prev_data);
      end
      if (busy) check("hdr_ready_busy", hdr_ready, 0);
      if (hdr_left > 0 && busy) check("s_ready_in_hdr", s_tready, 0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_tdata, 32'hDEADDEAD);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", m_tdata, b.data);
          check("beat_keep", m_tkeep, b.keep);
          check("beat_last", m_tlast, b.last);
          if (hdr_left > 0) begin
            if (hdr_left == 7 && lat_chk) check("lat_b0", cyc - acc_cyc, 0);
            hdr_left--;
          end else if (pay_first) begin
            if (lat_chk) check("lat_pay0", cyc - acc_cyc, 7);
            pay_first = 0;
          end
          if (b.last) begin
            model_count = model_count + 16'd1;
            post_chk = 1;
          end
        end
      end
      stall_prev = m_tvalid && !m_tready && !areset;
      prev_data  = m_tdata;
    end
  end

  function automatic desc_t rand_desc(input bit np);
    desc_t d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d.np = np;
    return d;
  endfunction

  task automatic send_pkt(input desc_t d, input int npay);
    bit hs = 0;
    logic [31:0] hw[7];
    @(posedge aclk); #1;
    hdr_valid = 1; hdr_opcode = d.op; hdr_psn = d.psn; hdr_dest_qp = d.qp;
    hdr_remote_addr = d.addr; hdr_frag_offset = d.off; hdr_length = d.len;
    hdr_partition_key = d.pkey; hdr_service_level = d.sl; hdr_no_payload = d.np;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk); hs = hdr_ready;
      @(posedge aclk); #1;
    end
    hdr_valid = 0;
    if (!hs) begin
      check("hdr_accept_timeout", 0, 1);
      return;
    end
    acc_cyc = cyc;
    hw[0] = {d.psn, d.op};       hw[1] = {8'h00, d.qp};     hw[2] = d.addr;
    hw[3] = {16'h0, d.off};      hw[4] = d.len;             hw[5] = {16'h0, d.pkey};
    hw[6] = {24'hABABAB, d.sl};
    for (int i = 0; i < 7; i++) exp_q.push_back('{hw[i], 4'hF, d.np && i == 6});
    hdr_left  = 7;
    pay_first = !d.np;
    if (!d.np) begin
      for (int i = 0; i < npay; i++) begin
        beat_t p = '{$urandom, 4'($urandom), i == npay - 1};
        exp_q.push_back(p);
        pay_q.push_back(p);
      end
    end
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge aclk); #1;
      done = !busy && exp_q.size() == 0;
    end
    noise_en  = 0;
    hdr_valid = 0;
    if (!done) check("pkt_timeout", 0, 1);
    @(negedge aclk);
  endtask

  initial begin
    desc_t d;
    areset = 1; hdr_valid = 0; hdr_no_payload = 0;
    hdr_opcode = 0; hdr_psn = 0; hdr_dest_qp = 0; hdr_remote_addr = 0;
    hdr_frag_offset = 0; hdr_length = 0; hdr_partition_key = 0; hdr_service_level = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_hdr_ready", hdr_ready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", tx_pkt_count, 0);
    @(posedge aclk); #1 areset = 0;
    @(negedge aclk);
    check("idle_hdr_ready", hdr_ready, 1);

    // Directed packet with full-rate sink: exact layout and latency.
    d = '{8'h0A, 24'h000123, 24'h000011, 32'h80001000, 16'h0, 32'd8, 16'hFFFF, 8'd3, 1'b0};
    rdy_mode = 0; src_always = 1; lat_chk = 1;
    send_pkt(d, 2);
    wait_done();
    lat_chk = 0;
    check("count_dir1", tx_pkt_count, 1);

    // Same packet with a toggling sink.
    rdy_mode = 1;
    send_pkt(d, 2);
    wait_done();

    // Header-only packet.
    d.np = 1;
    send_pkt(d, 0);
    wait_done();

    // Descriptor noise during header and payload.
    rdy_mode = 2; src_always = 0;
    for (int i = 0; i < 6; i++) begin
      send_pkt(rand_desc(i % 3 == 2), $urandom_range(1, 6));
      noise_en = 1;
      wait_done();
    end

    // Reset while header beat 3 is on the bus.
    rdy_mode = 0;
    send_pkt(rand_desc(0), 3);
    for (int i = 0; i < 50 && hdr_left != 4; i++) begin
      @(posedge aclk); #1;
    end
    check("reached_beat3", hdr_left, 4);
    areset = 1;
    @(posedge aclk); #2;
    exp_q.delete(); pay_q.delete(); s_tvalid = 0;
    hdr_left = 0; pay_first = 0; post_chk = 0; model_count = 0;
    @(negedge aclk);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", tx_pkt_count, 0);
    @(posedge aclk); #1 areset = 0;
    send_pkt(rand_desc(0), 2);
    wait_done();
    check("count_after_rst", tx_pkt_count, 1);

    // Random traffic under a random sink.
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send_pkt(rand_desc($urandom_range(0, 3) == 0), $urandom_range(1, 8));
      wait_done();
    end

    // Counter wrap: preload near the top, then finish header-only packets.
    force dut.pkt_cnt_q = 16'hFFFE;
    #1 release dut.pkt_cnt_q;
    model_count = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      send_pkt(rand_desc(1), 0);
      wait_done();
      if (i == 1) check("count_wrap", tx_pkt_count, 16'h0000);
    end

    repeat (3) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
